// File: rtl/comp_mult_pipe.sv
// Fully pipelined signed complex multiplier with per-transaction conjugate mode.
// Stage 1 forms the four partial products, stage 2 combines them, and later stages only add delay.
module comp_mult_pipe #(
  parameter int DWIDTH = 8,
  parameter int PIPE   = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sw_rst,
  input  logic                         op_val,
  output logic                         op_rdy,
  input  logic [4*DWIDTH-1:0]          op_data,
  input  logic                         op_conj,
  output logic                         res_val,
  input  logic                         res_rdy,
  output logic [2*(2*DWIDTH+1)-1:0]    res_data
);

  localparam int PW = 2 * DWIDTH;
  localparam int RW = PW + 1;

  logic signed [DWIDTH-1:0] x1, y1, x2, y2;
  logic signed [PW-1:0]     m_xx, m_yy, m_xy, m_yx;
  logic signed [PW-1:0]     p_xx, p_yy, p_xy, p_yx;
  logic                     conj_q;
  logic signed [RW-1:0]     xr_n, yr_n;
  logic signed [RW-1:0]     xr_q [2:PIPE];
  logic signed [RW-1:0]     yr_q [2:PIPE];
  logic [PIPE:1]            v;
  logic                     en;
  logic                     accept;

  assign x1 = op_data[4*DWIDTH-1 -: DWIDTH];
  assign y1 = op_data[3*DWIDTH-1 -: DWIDTH];
  assign x2 = op_data[2*DWIDTH-1 -: DWIDTH];
  assign y2 = op_data[DWIDTH-1   -: DWIDTH];

  // The whole pipeline moves as one; only a held result at the output can stop it.
  assign en     = ~v[PIPE] | res_rdy;
  assign op_rdy = en & ~sw_rst;
  assign accept = op_val & op_rdy;

  assign m_xx = PW'(x1) * PW'(x2);
  assign m_yy = PW'(y1) * PW'(y2);
  assign m_xy = PW'(x1) * PW'(y2);
  assign m_yx = PW'(x2) * PW'(y1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_xx   <= '0;
      p_yy   <= '0;
      p_xy   <= '0;
      p_yx   <= '0;
      conj_q <= 1'b0;
    end else if (sw_rst) begin
      p_xx   <= '0;
      p_yy   <= '0;
      p_xy   <= '0;
      p_yx   <= '0;
      conj_q <= 1'b0;
    end else if (en) begin
      // Bubbles carry zero data so res_data reads 0 whenever res_val is low.
      p_xx   <= accept ? m_xx : '0;
      p_yy   <= accept ? m_yy : '0;
      p_xy   <= accept ? m_xy : '0;
      p_yx   <= accept ? m_yx : '0;
      conj_q <= accept & op_conj;
    end
  end

  // One extra bit over the product width keeps the worst-case sum exact.
  assign xr_n = conj_q ? (RW'(p_xx) + RW'(p_yy)) : (RW'(p_xx) - RW'(p_yy));
  assign yr_n = conj_q ? (RW'(p_yx) - RW'(p_xy)) : (RW'(p_xy) + RW'(p_yx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 2; k <= PIPE; k++) begin
        xr_q[k] <= '0;
        yr_q[k] <= '0;
      end
    end else if (sw_rst) begin
      for (int k = 2; k <= PIPE; k++) begin
        xr_q[k] <= '0;
        yr_q[k] <= '0;
      end
    end else if (en) begin
      xr_q[2] <= xr_n;
      yr_q[2] <= yr_n;
      for (int k = 3; k <= PIPE; k++) begin
        xr_q[k] <= xr_q[k-1];
        yr_q[k] <= yr_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else if (sw_rst) begin
      v <= '0;
    end else if (en) begin
      v <= {v[PIPE-1:1], accept};
    end
  end

  assign res_val  = v[PIPE];
  assign res_data = {xr_q[PIPE], yr_q[PIPE]};

endmodule
